votrax_seq: RTL and testbench
=============================

VOTRAX_SEQ -- requirements
Module: votrax_seq

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, FIFO address width (depth 2^FIFO_AW phonemes).
REQ-002 SHALL have parameter CE_DIV, default 8, clk cycles per speech-chip clock-enable pulse (range 2..255).
REQ-003 SHALL have parameter TMO, default 64, clk cycles allowed for AR to fall after a latch strobe.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr  in  1  one-cycle write strobe from the sound CPU address decode.
REQ-007 wdata  in  8  [5:0] phoneme code, [7:6] inflection.
REQ-008 flush  in  1  synchronous FIFO clear and sequencer abort.
REQ-009 ar  in  1  speech-chip acknowledge/request; 1 = ready for next phoneme.
REQ-010 ph_code  out  6  phoneme presented to the speech chip.
REQ-011 inflect  out  2  inflection presented with ph_code.
REQ-012 latch_n  out  1  active-low phoneme latch strobe.
REQ-013 votrax_ce  out  1  one-cycle clock-enable pulse for the speech chip.
REQ-014 full / empty  out  1 each  FIFO status.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 ovf  out  1  sticky: write dropped because FIFO full.
REQ-017 tmo_err  out  1  sticky: AR failed to fall within TMO cycles (only with macro, REQ-033).

Function
REQ-018 votrax_ce SHALL pulse high for exactly one clk every CE_DIV clks, free-running, from a counter that wraps CE_DIV-1 to 0.
REQ-019 wr with full=0 SHALL push wdata; wr with full=1 SHALL discard wdata, leave FIFO unchanged and set ovf.
REQ-020 Simultaneous push and pop SHALL be allowed in any state, including full (pop frees the slot first, so the push succeeds, occupancy unchanged).
REQ-021 Pointers SHALL wrap modulo 2^FIFO_AW; occupancy counter FIFO_AW+1 bits; full at 2^FIFO_AW, empty at 0.
REQ-022 FSM states: IDLE, LATCH, WAIT_FALL, WAIT_RISE.
REQ-023 IDLE -> LATCH when empty=0 and ar=1; same cycle pops head entry into ph_code/inflect registers.
REQ-024 LATCH: latch_n=0 for exactly one clk, then -> WAIT_FALL; ph_code/inflect SHALL remain stable from LATCH until the next pop.
REQ-025 WAIT_FALL -> WAIT_RISE when ar=0.
REQ-026 WAIT_RISE -> IDLE when ar=1; the next phoneme SHALL not be latched earlier than the cycle after IDLE is re-entered.
REQ-027 Latency: FIFO empty, ar=1, wr at cycle N -> latch_n low at cycle N+2.
REQ-028 flush SHALL clear FIFO, force IDLE and latch_n=1, and keep ph_code; flush wins over a simultaneous wr (write dropped, ovf not set).
REQ-029 ovf and tmo_err SHALL clear only on reset or flush.

Reset
REQ-030 On reset: FIFO empty, empty=1, full=0, state IDLE, busy=0, latch_n=1, ph_code=6'h3F (stop/pause), inflect=0, ovf=0, tmo_err=0, CE counter=0, votrax_ce=0.
REQ-031 Reset asserted mid-sequence SHALL abort within one clk with no further latch_n pulse; outputs take reset values on the next edge.

Configuration
REQ-032 Macro VOTRAX_SEQ_TIMEOUT_EN SHALL select the AR timeout feature.
REQ-033 Defined: counter runs in WAIT_FALL; if ar is still 1 after TMO clks, set tmo_err and -> IDLE (phoneme considered spoken).
REQ-034 Undefined: no counter, WAIT_FALL waits indefinitely, tmo_err tied to 0.

Verification
REQ-035 Reset, ar=1, write 8'h45 -> latch_n low exactly one clk at write+2, ph_code=6'h05, inflect=2'b01, busy=1.
REQ-036 Write 16 phonemes back-to-back (depth 16), 17th write -> full=1, ovf=1, 17th discarded; drain order matches write order.
REQ-037 ar held 1 with 3 queued, ar pulsed low 10 clks then high after each latch -> exactly 3 latch_n pulses, none while ar=0.
REQ-038 CE_DIV=8 -> votrax_ce high on every 8th clk, never two consecutive clks.
REQ-039 Timeout build, ar stuck 1 after latch -> tmo_err=1 at TMO clks, FSM IDLE, next phoneme latched; non-timeout build stays busy.
REQ-040 flush asserted during WAIT_RISE with 5 queued and wr in same cycle -> empty=1, IDLE, ovf=0, no further latch_n.

Source files
------------

// File: rtl/votrax_seq_if.sv
// Votrax sequencer bus bundle: CPU-side write port plus speech-chip handshake.
// The sequencer takes the slave view; whoever drives the CPU side and models
// the speech chip's AR line takes the master view.
interface votrax_seq_if;
    logic       wr;
    logic [7:0] wdata;
    logic       flush;
    logic       ar;
    logic [5:0] ph_code;
    logic [1:0] inflect;
    logic       latch_n;
    logic       votrax_ce;
    logic       full;
    logic       empty;
    logic       busy;
    logic       ovf;
    logic       tmo_err;

    modport master (
        output wr, wdata, flush, ar,
        input  ph_code, inflect, latch_n, votrax_ce, full, empty, busy, ovf, tmo_err
    );

    modport slave (
        input  wr, wdata, flush, ar,
        output ph_code, inflect, latch_n, votrax_ce, full, empty, busy, ovf, tmo_err
    );
endinterface

// File: rtl/votrax_seq.sv
// Votrax phoneme sequencer: buffers phoneme writes from the sound CPU in a FIFO
// and hands them to the speech chip one at a time using the AR handshake
// (latch, wait for AR to fall, wait for AR to rise). Also generates the
// free-running clock-enable for the speech chip.
// Optional feature: define VOTRAX_SEQ_TIMEOUT_EN to give up on a phoneme whose
// AR never falls after TMO cycles and flag it on tmo_err.
module votrax_seq #(
    parameter int FIFO_AW = 4,
    parameter int CE_DIV  = 8,
    parameter int TMO     = 64
) (
    input  logic        clk,
    input  logic        reset,
    votrax_seq_if.slave bus
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [7:0]         CE_LAST  = 8'(CE_DIV - 1);
    localparam logic [5:0]         PH_STOP  = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LATCH     = 2'd1,
        ST_WAIT_FALL = 2'd2,
        ST_WAIT_RISE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic [7:0]           mem_q [DEPTH];
    logic [5:0]           ph_code_q, ph_code_d;
    logic [1:0]           inflect_q, inflect_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           ce_cnt_q, ce_cnt_d;
    logic                 ce_q, ce_d;

    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 push;
    logic [7:0]           head;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A pop only happens from IDLE when the chip is ready; flush suppresses it.
    assign pop  = (state_q == ST_IDLE) && !empty && bus.ar && !bus.flush;
    // A pop in the same cycle frees the head slot, so a write into a full FIFO
    // still lands when the sequencer is popping.
    assign push = bus.wr && !bus.flush && (!full || pop);

`ifdef VOTRAX_SEQ_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;
    logic             tmo_hit;

    assign tmo_hit = (state_q == ST_WAIT_FALL) && bus.ar && (tmo_cnt_q == TMO_LAST);

    // Timeout counter only advances while waiting for AR to fall; the error
    // flag is sticky until reset or flush.
    always_comb begin
        tmo_cnt_d = (state_q == ST_WAIT_FALL) ? tmo_cnt_q + TMO_ONE : '0;
        tmo_err_d = tmo_err_q | tmo_hit;
        if (bus.flush) begin
            tmo_cnt_d = '0;
            tmo_err_d = 1'b0;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign bus.tmo_err = tmo_err_q;
`else
    // Without the timeout feature TMO has no effect and the flag never sets.
    assign bus.tmo_err = (TMO < 0);
`endif

    // Free-running speech-chip clock enable: one pulse per CE_DIV cycles.
    always_comb begin
        ce_cnt_d = (ce_cnt_q == CE_LAST) ? 8'd0 : ce_cnt_q + 8'd1;
        ce_d     = (ce_cnt_q == CE_LAST);
    end

    // FIFO pointers/occupancy, presented phoneme registers and overflow flag.
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = count_q;
        ph_code_d = ph_code_q;
        inflect_d = inflect_q;
        ovf_d     = ovf_q | (bus.wr && full && !pop);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (pop) begin
            ph_code_d = head[5:0];
            inflect_d = head[7:6];
        end

        // Flush empties the FIFO but leaves the last phoneme on the chip pins.
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

    // Handshake sequencer: latch one phoneme, then follow AR down and back up.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (pop) state_d = ST_LATCH;
            ST_LATCH:     state_d = ST_WAIT_FALL;
            ST_WAIT_FALL: begin
                if (!bus.ar) begin
                    state_d = ST_WAIT_RISE;
                end
`ifdef VOTRAX_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_WAIT_RISE: if (bus.ar) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d = ST_IDLE;
        end
    end

    // FIFO storage carries no reset; only pointers and occupancy define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wdata;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ph_code_q <= PH_STOP;
            inflect_q <= 2'b00;
            ovf_q     <= 1'b0;
            ce_cnt_q  <= 8'd0;
            ce_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ph_code_q <= ph_code_d;
            inflect_q <= inflect_d;
            ovf_q     <= ovf_d;
            ce_cnt_q  <= ce_cnt_d;
            ce_q      <= ce_d;
        end
    end

    assign bus.ph_code   = ph_code_q;
    assign bus.inflect   = inflect_q;
    assign bus.latch_n   = (state_q != ST_LATCH);
    assign bus.votrax_ce = ce_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_votrax_seq.sv
// Testbench for votrax_seq: a scoreboard queue holds the phonemes expected at
// the chip in order; a monitor pops and compares on every latch_n strobe.
// A small speech-chip model drops AR for 10 clocks after each latch.
module tb_votrax_seq;

    localparam int TMO = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    votrax_seq_if vif();

    logic ar_chip   = 1'b1;
    logic ar_block  = 1'b0;
    bit   chip_auto = 1'b1;
    assign vif.ar = ar_chip & ~ar_block;

    votrax_seq #(.FIFO_AW(4), .CE_DIV(8), .TMO(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    int         n_latch = 0;
    logic [7:0] sb[$];
    logic       prev_ar      = 1'b1;
    logic       prev_latch_n = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Monitor: every latch strobe must match the oldest queued phoneme.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset && vif.latch_n === 1'b0) begin
            n_latch++;
            chk("latch_one_cycle", 32'(prev_latch_n), 32'd1);
            chk("latch_after_ar_ready", 32'(prev_ar), 32'd1);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_latch: ph_code 0x%0h with nothing queued", vif.ph_code);
            end else begin
                e = sb.pop_front();
                chk("latch_ph_code", 32'(vif.ph_code), 32'(e[5:0]));
                chk("latch_inflect", 32'(vif.inflect), 32'(e[7:6]));
            end
        end
        prev_ar      = vif.ar;
        prev_latch_n = vif.latch_n;
    end

    // Speech-chip model: after a latch, AR goes low for 10 clocks.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (chip_auto && vif.latch_n === 1'b0) begin
                @(posedge clk); #1;
                ar_chip = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                ar_chip = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic write(input logic [7:0] d, input bit accepted);
        vif.wr    = 1'b1;
        vif.wdata = d;
        if (accepted) sb.push_back(d);
        tick();
        vif.wr = 1'b0;
    endtask

    task automatic do_flush();
        vif.flush = 1'b1;
        sb.delete();
        tick();
        vif.flush = 1'b0;
    endtask

    task automatic wait_quiet(input int max, input string name);
        int k = 0;
        while (!(vif.busy === 1'b0 && vif.empty === 1'b1 && vif.ar === 1'b1) && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(k < max), 32'd1);
        tick();
    endtask

    task automatic wait_latch(input int max, input string name);
        int k = 0;
        @(negedge clk);
        while (vif.latch_n !== 1'b0 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(k < max), 32'd1);
    endtask

    task automatic test_latency();
        vif.wr    = 1'b1;
        vif.wdata = 8'h45;
        sb.push_back(8'h45);
        @(negedge clk);
        chk("lat_cycle_n", 32'(vif.latch_n), 32'd1);
        tick();
        vif.wr = 1'b0;
        @(negedge clk);
        chk("lat_cycle_n1", 32'(vif.latch_n), 32'd1);
        @(negedge clk);
        chk("lat_cycle_n2_latch", 32'(vif.latch_n), 32'd0);
        chk("lat_ph_code", 32'(vif.ph_code), 32'h05);
        chk("lat_inflect", 32'(vif.inflect), 32'd1);
        chk("lat_busy", 32'(vif.busy), 32'd1);
        @(negedge clk);
        chk("lat_cycle_n3", 32'(vif.latch_n), 32'd1);
        tick();
        wait_quiet(100, "lat_drain_bound");
    endtask

    task automatic test_full_ovf();
        int l0;
        ar_block = 1'b1;
        for (int i = 0; i < 16; i++) write(8'(i * 37 + 5), 1'b1);
        @(negedge clk);
        chk("fill_full", 32'(vif.full), 32'd1);
        chk("fill_empty", 32'(vif.empty), 32'd0);
        chk("fill_ovf", 32'(vif.ovf), 32'd0);
        tick();
        l0 = n_latch;
        // Pop and push in the same cycle while full: write must be accepted.
        ar_block  = 1'b0;
        vif.wr    = 1'b1;
        vif.wdata = 8'hA5;
        sb.push_back(8'hA5);
        tick();
        vif.wr   = 1'b0;
        ar_block = 1'b1;
        @(negedge clk);
        chk("pushpop_full", 32'(vif.full), 32'd1);
        chk("pushpop_ovf", 32'(vif.ovf), 32'd0);
        tick();
        write(8'hFF, 1'b0);
        @(negedge clk);
        chk("ovf_full", 32'(vif.full), 32'd1);
        chk("ovf_set", 32'(vif.ovf), 32'd1);
        tick();
        ar_block = 1'b0;
        wait_quiet(400, "drain_bound");
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_latches", 32'(n_latch - l0), 32'd17);
        chk("ovf_sticky", 32'(vif.ovf), 32'd1);
        do_flush();
        @(negedge clk);
        chk("ovf_cleared_by_flush", 32'(vif.ovf), 32'd0);
        tick();
    endtask

    task automatic test_ar_handshake();
        int l0;
        ar_block = 1'b1;
        write(8'h81, 1'b1);
        write(8'h12, 1'b1);
        write(8'hC3, 1'b1);
        l0 = n_latch;
        ar_block = 1'b0;
        wait_quiet(200, "hs_bound");
        chk("hs_latches", 32'(n_latch - l0), 32'd3);
        chk("hs_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic test_ce();
        int last = -1;
        int pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (vif.votrax_ce === 1'b1) begin
                pulses++;
                if (last >= 0) chk("ce_period", 32'(c - last), 32'd8);
                last = c;
            end
        end
        chk("ce_pulses_in_40", 32'(pulses), 32'd5);
        tick();
    endtask

    task automatic test_flush();
        int k = 0;
        int l0;
        ar_block = 1'b1;
        for (int i = 0; i < 6; i++) write(8'(8'h40 + i * 9), 1'b1);
        ar_block = 1'b0;
        @(negedge clk);
        while (vif.ar !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("flush_ar_low_bound", 32'(k < 50), 32'd1);
        tick();
        // AR was sampled low once: sequencer is now waiting for it to rise.
        vif.flush = 1'b1;
        vif.wr    = 1'b1;
        vif.wdata = 8'h77;
        sb.delete();
        tick();
        vif.flush = 1'b0;
        vif.wr    = 1'b0;
        l0 = n_latch;
        @(negedge clk);
        chk("flush_empty", 32'(vif.empty), 32'd1);
        chk("flush_idle", 32'(vif.busy), 32'd0);
        chk("flush_ovf", 32'(vif.ovf), 32'd0);
        chk("flush_latch_n", 32'(vif.latch_n), 32'd1);
        chk("flush_keeps_ph", 32'(vif.ph_code), 32'h00);
        repeat (30) @(negedge clk);
        chk("flush_no_more_latch", 32'(n_latch - l0), 32'd0);
        tick();
        wait_quiet(50, "flush_quiet_bound");
    endtask

    task automatic test_reset_mid();
        int l0;
        ar_block = 1'b1;
        write(8'h4A, 1'b1);
        write(8'h0B, 1'b1);
        write(8'h8C, 1'b1);
        ar_block = 1'b0;
        wait_latch(20, "rst_mid_latch_bound");
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        l0 = n_latch;
        @(negedge clk);
        chk("rst_mid_busy", 32'(vif.busy), 32'd0);
        chk("rst_mid_latch_n", 32'(vif.latch_n), 32'd1);
        chk("rst_mid_ph_code", 32'(vif.ph_code), 32'h3F);
        chk("rst_mid_empty", 32'(vif.empty), 32'd1);
        tick();
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("rst_mid_no_latch", 32'(n_latch - l0), 32'd0);
        tick();
        wait_quiet(50, "rst_mid_quiet_bound");
    endtask

    task automatic test_timeout();
        int k = 0;
        chip_auto = 1'b0;
        ar_block  = 1'b1;
        write(8'h21, 1'b1);
        write(8'h62, 1'b1);
        ar_block = 1'b0;
        wait_latch(20, "tmo_first_latch_bound");
`ifdef VOTRAX_SEQ_TIMEOUT_EN
        while (vif.tmo_err !== 1'b1 && k < 3 * TMO) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_latency_in_range", 32'(k >= TMO && k <= TMO + 2), 32'd1);
        chk("tmo_fsm_idle", 32'(vif.busy), 32'd0);
        wait_latch(20, "tmo_second_latch_bound");
        tick();
        wait_quiet(4 * TMO, "tmo_second_bound");
        chk("tmo_sb_empty", 32'(sb.size()), 32'd0);
        chk("tmo_err_sticky", 32'(vif.tmo_err), 32'd1);
`else
        repeat (2 * TMO) begin
            @(negedge clk);
            k++;
        end
        chk("notmo_still_busy", 32'(vif.busy), 32'd1);
        chk("notmo_err_zero", 32'(vif.tmo_err), 32'd0);
        chk("notmo_second_pending", 32'(sb.size()), 32'd1);
        tick();
`endif
        do_flush();
        @(negedge clk);
        chk("tmo_err_cleared", 32'(vif.tmo_err), 32'd0);
        chk("tmo_flush_idle", 32'(vif.busy), 32'd0);
        tick();
        chip_auto = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        vif.wr    = 1'b0;
        vif.wdata = 8'h00;
        vif.flush = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("rst_empty", 32'(vif.empty), 32'd1);
        chk("rst_full", 32'(vif.full), 32'd0);
        chk("rst_busy", 32'(vif.busy), 32'd0);
        chk("rst_latch_n", 32'(vif.latch_n), 32'd1);
        chk("rst_ph_code", 32'(vif.ph_code), 32'h3F);
        chk("rst_inflect", 32'(vif.inflect), 32'd0);
        chk("rst_ovf", 32'(vif.ovf), 32'd0);
        chk("rst_tmo_err", 32'(vif.tmo_err), 32'd0);
        chk("rst_votrax_ce", 32'(vif.votrax_ce), 32'd0);
        tick();
        reset = 1'b0;

        test_latency();
        test_full_ovf();
        test_ar_handshake();
        test_ce();
        test_flush();
        test_reset_mid();
        test_timeout();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
